// File: rtl/irrigation_pkg.sv
// Shared encodings and default timing for the irrigation valve sequencer.
// State codes are visible on the display path, so their values are fixed.
package irrigation_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StSprinkle = 3'd1,
    StDrip     = 3'd2,
    StCooldown = 3'd3,
    StRefill   = 3'd4,
    StFault    = 3'd5
  } state_e;

  localparam logic [1:0] LvlEmpty = 2'b00;
  localparam logic [1:0] LvlLow   = 2'b01;
  localparam logic [1:0] LvlMid   = 2'b10;
  localparam logic [1:0] LvlFull  = 2'b11;

  localparam int unsigned TimerWidth = 6;

  localparam int unsigned DefSprinklerTime = 30;
  localparam int unsigned DefDripTime      = 20;
  localparam int unsigned DefSpecificTime  = 15;
  localparam int unsigned DefGapTime       = 5;
  localparam int unsigned DefRefillMax     = 60;

endpackage

// File: rtl/valve_sequencer_if.sv
// Request/level inputs and actuator/status outputs of the valve sequencer.
// master drives requests (decision logic side), slave is the sequencer.
interface valve_sequencer_if;
  import irrigation_pkg::*;

  logic                  one_hz;
  logic                  sprinkler_req;
  logic                  drip_req;
  logic                  specific_req;
  logic [1:0]            water_box;
  logic                  button;

  logic [2:0]            state;
  logic                  valve_sprinkler;
  logic                  valve_drip;
  logic                  pump_fill;
  logic                  fault;
  logic [TimerWidth-1:0] seconds_left;
  logic                  time_over;

  modport master (
    output one_hz, sprinkler_req, drip_req, specific_req, water_box, button,
    input  state, valve_sprinkler, valve_drip, pump_fill, fault, seconds_left, time_over
  );

  modport slave (
    input  one_hz, sprinkler_req, drip_req, specific_req, water_box, button,
    output state, valve_sprinkler, valve_drip, pump_fill, fault, seconds_left, time_over
  );

endinterface

// File: rtl/seconds_timer.sv
// Loadable 6-bit down-counter advanced by the 1 Hz tick; load beats tick.
// o_expire flags the tick that finishes the count (tick while count==1).
module seconds_timer
  import irrigation_pkg::*;
(
  input  logic                  clock_50MHz,
  input  logic                  reset_n,
  input  logic                  i_load,
  input  logic [TimerWidth-1:0] i_load_value,
  input  logic                  i_tick,
  output logic [TimerWidth-1:0] o_count,
  output logic                  o_expire
);

  logic [TimerWidth-1:0] r_count;

  always_ff @(posedge clock_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_tick && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count  = r_count;
  assign o_expire = i_tick && (r_count == TimerWidth'(1));

endmodule

// File: rtl/valve_sequencer.sv
// Owns valve timing: mutually exclusive sprinkler/drip cycles, cooldown gaps,
// tank refill with timeout fault. Actuators decode from the registered state.
module valve_sequencer
  import irrigation_pkg::*;
#(
  parameter int unsigned SPRINKLER_TIME = DefSprinklerTime,
  parameter int unsigned DRIP_TIME      = DefDripTime,
  parameter int unsigned SPECIFIC_TIME  = DefSpecificTime,
  parameter int unsigned GAP_TIME       = DefGapTime,
  parameter int unsigned REFILL_MAX     = DefRefillMax
) (
  input logic               clock_50MHz,
  input logic               reset_n,
  valve_sequencer_if.slave  bus
);

  localparam logic [TimerWidth-1:0] LdSprinkle = TimerWidth'(SPRINKLER_TIME);
  localparam logic [TimerWidth-1:0] LdDrip     = TimerWidth'(DRIP_TIME);
  localparam logic [TimerWidth-1:0] LdSpecific = TimerWidth'(SPECIFIC_TIME);
  localparam logic [TimerWidth-1:0] LdGap      = TimerWidth'(GAP_TIME);
  localparam logic [TimerWidth-1:0] LdRefill   = TimerWidth'(REFILL_MAX);

  state_e                r_state;
  logic                  r_valve_sprinkler;
  logic                  r_valve_drip;
  logic                  r_pump_fill;
  logic                  r_fault;
  logic                  r_time_over;

  logic                  r_btn_meta;
  logic                  r_btn_sync;
  logic                  r_btn_prev;
  logic                  w_btn_pulse;

  state_e                w_next_state;
  logic                  w_time_over;
  logic                  w_load;
  logic [TimerWidth-1:0] w_load_value;
  logic [TimerWidth-1:0] w_count;
  logic                  w_expire;
  logic                  w_empty;

  // Two-flop synchronizer, then edge register; pulse is valid the cycle after sync.
  always_ff @(posedge clock_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_btn_meta <= 1'b0;
      r_btn_sync <= 1'b0;
      r_btn_prev <= 1'b0;
    end else begin
      r_btn_meta <= bus.button;
      r_btn_sync <= r_btn_meta;
      r_btn_prev <= r_btn_sync;
    end
  end

  assign w_btn_pulse = r_btn_sync && !r_btn_prev;
  assign w_empty     = (bus.water_box == LvlEmpty);

  always_comb begin
    w_next_state = r_state;
    w_time_over  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_empty) begin
          w_next_state = StRefill;
        end else if (bus.sprinkler_req && (bus.water_box >= LvlMid)) begin
          w_next_state = StSprinkle;
        end else if (bus.drip_req || (bus.sprinkler_req && (bus.water_box == LvlLow))) begin
          w_next_state = StDrip;
        end
      end
      StSprinkle, StDrip: begin
        // Empty tank outranks the button, which outranks normal expiry.
        if (w_empty) begin
          w_next_state = StRefill;
        end else if (w_btn_pulse) begin
          w_next_state = StCooldown;
        end else if (w_expire) begin
          w_next_state = StCooldown;
          w_time_over  = 1'b1;
        end
      end
      StCooldown: begin
        if (w_expire) begin
          w_next_state = StIdle;
        end
      end
      StRefill: begin
        if (bus.water_box == LvlFull) begin
          w_next_state = StCooldown;
        end else if (w_expire) begin
          w_next_state = StFault;
        end
      end
      StFault: begin
        if (w_btn_pulse) begin
          w_next_state = StIdle;
        end
      end
      default: begin
        w_next_state = StIdle;
      end
    endcase
  end

  // Every transition reloads the timer; untimed states load 0 so seconds_left reads 0.
  always_comb begin
    w_load       = (w_next_state != r_state);
    w_load_value = '0;
    unique case (w_next_state)
      StSprinkle: w_load_value = LdSprinkle;
      StDrip:     w_load_value = bus.specific_req ? LdSpecific : LdDrip;
      StCooldown: w_load_value = LdGap;
      StRefill:   w_load_value = LdRefill;
      default:    w_load_value = '0;
    endcase
  end

  seconds_timer u_timer (
    .clock_50MHz  (clock_50MHz),
    .reset_n      (reset_n),
    .i_load       (w_load),
    .i_load_value (w_load_value),
    .i_tick       (bus.one_hz),
    .o_count      (w_count),
    .o_expire     (w_expire)
  );

  always_ff @(posedge clock_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state           <= StIdle;
      r_valve_sprinkler <= 1'b0;
      r_valve_drip      <= 1'b0;
      r_pump_fill       <= 1'b0;
      r_fault           <= 1'b0;
      r_time_over       <= 1'b0;
    end else begin
      r_state           <= w_next_state;
      r_valve_sprinkler <= (w_next_state == StSprinkle);
      r_valve_drip      <= (w_next_state == StDrip);
      r_pump_fill       <= (w_next_state == StRefill);
      r_fault           <= (w_next_state == StFault);
      r_time_over       <= w_time_over;
    end
  end

  assign bus.state           = r_state;
  assign bus.valve_sprinkler = r_valve_sprinkler;
  assign bus.valve_drip      = r_valve_drip;
  assign bus.pump_fill       = r_pump_fill;
  assign bus.fault           = r_fault;
  assign bus.seconds_left    = w_count;
  assign bus.time_over       = r_time_over;

endmodule

// File: tb/tb_valve_sequencer.sv
// Scoreboard bench for valve_sequencer: stimulus queues expected state entries
// and probes; a monitor compares them when the state changes or a probe fires.
module tb_valve_sequencer;

  typedef struct packed {
    logic [2:0] st;
    logic [5:0] secs;
    logic       tover;
    bit         use_tick;
    int         tick_at;
    bit         use_cyc;
    int         cyc_at;
  } exp_t;

  exp_t  sb[$];
  string sb_tag[$];

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   tick_cnt = 0;
  int   cyc      = 0;
  bit   probe    = 1'b0;
  logic [2:0] prev_state;

  valve_sequencer_if vif ();

  valve_sequencer dut (
    .clock_50MHz (clk),
    .reset_n     (rst_n),
    .bus         (vif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  // {valve_sprinkler, valve_drip, pump_fill, fault} for each state code
  function automatic logic [3:0] act_of(logic [2:0] s);
    case (s)
      3'd1:    return 4'b1000;
      3'd2:    return 4'b0100;
      3'd4:    return 4'b0010;
      3'd5:    return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic void expect_ev(string tag, logic [2:0] st, int secs, logic tover,
                                    bit use_tick, int tick_at, bit use_cyc, int cyc_at);
    exp_t e;
    e.st = st; e.secs = 6'(secs); e.tover = tover;
    e.use_tick = use_tick; e.tick_at = tick_at;
    e.use_cyc = use_cyc; e.cyc_at = cyc_at;
    sb.push_back(e);
    sb_tag.push_back(tag);
  endfunction

  // Monitor
  initial begin
    prev_state = 3'd0;
    forever begin
      @(negedge clk);
      if ((vif.state !== prev_state) || probe) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event: state %0d secs %0d, required no event",
                   vif.state, vif.seconds_left);
        end else begin
          exp_t  e;
          string t;
          e = sb.pop_front();
          t = sb_tag.pop_front();
          check({t, ".state"}, 32'(vif.state), 32'(e.st));
          check({t, ".secs"}, 32'(vif.seconds_left), 32'(e.secs));
          check({t, ".time_over"}, 32'(vif.time_over), 32'(e.tover));
          check({t, ".actuators"},
                32'({vif.valve_sprinkler, vif.valve_drip, vif.pump_fill, vif.fault}),
                32'(act_of(e.st)));
          if (e.use_tick) check({t, ".tick"}, tick_cnt, e.tick_at);
          if (e.use_cyc)  check({t, ".cycle"}, cyc, e.cyc_at);
        end
      end else if (vif.time_over !== 1'b0) begin
        n_tests++;
        n_fail++;
        $display("FAIL stray_time_over: got %b in state %0d, expected 0",
                 vif.time_over, vif.state);
      end
      prev_state = vif.state;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(int n);
    repeat (n) step();
  endtask

  task automatic tick(int n);
    for (int i = 0; i < n; i++) begin
      step();
      vif.one_hz = 1'b1;
      tick_cnt++;
      step();
      vif.one_hz = 1'b0;
      step();
    end
  endtask

  task automatic do_probe(string tag, logic [2:0] st, int secs);
    expect_ev(tag, st, secs, 1'b0, 1'b0, 0, 1'b0, 0);
    step();
    probe = 1'b1;
    @(negedge clk);
    #1;
    probe = 1'b0;
  endtask

  initial begin
    int p;
    vif.one_hz        = 1'b0;
    vif.sprinkler_req = 1'b0;
    vif.drip_req      = 1'b0;
    vif.specific_req  = 1'b0;
    vif.water_box     = 2'b11;
    vif.button        = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("reset.state", 32'(vif.state), 0);
    check("reset.valve_sprinkler", 32'(vif.valve_sprinkler), 0);
    check("reset.valve_drip", 32'(vif.valve_drip), 0);
    check("reset.pump_fill", 32'(vif.pump_fill), 0);
    check("reset.fault", 32'(vif.fault), 0);
    check("reset.seconds_left", 32'(vif.seconds_left), 0);
    check("reset.time_over", 32'(vif.time_over), 0);
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(3);

    // Full sprinkler cycle: 30 ticks, pulse into 5-tick cooldown, back to idle
    step();
    vif.sprinkler_req = 1'b1;
    expect_ev("spr.enter", 3'd1, 30, 1'b0, 1'b0, 0, 1'b1, cyc + 1);
    wait_cyc(2);
    vif.sprinkler_req = 1'b0;
    tick(10);
    do_probe("spr.mid", 3'd1, 20);
    expect_ev("spr.done", 3'd3, 5, 1'b1, 1'b1, tick_cnt + 20, 1'b0, 0);
    expect_ev("spr.gap_end", 3'd0, 0, 1'b0, 1'b1, tick_cnt + 25, 1'b0, 0);
    tick(25);
    wait_cyc(2);

    // Low tank sprinkler request becomes specific drip; entry tick is not counted
    step();
    vif.water_box     = 2'b01;
    vif.sprinkler_req = 1'b1;
    vif.specific_req  = 1'b1;
    vif.one_hz        = 1'b1;
    tick_cnt++;
    expect_ev("drip.enter", 3'd2, 15, 1'b0, 1'b0, 0, 1'b1, cyc + 1);
    step();
    vif.one_hz = 1'b0;
    step();
    vif.sprinkler_req = 1'b0;
    vif.specific_req  = 1'b0;
    tick(5);
    do_probe("drip.mid", 3'd2, 10);
    expect_ev("drip.done", 3'd3, 5, 1'b1, 1'b1, tick_cnt + 10, 1'b0, 0);
    expect_ev("drip.gap_end", 3'd0, 0, 1'b0, 1'b1, tick_cnt + 15, 1'b0, 0);
    tick(15);
    wait_cyc(2);
    vif.water_box = 2'b11;

    // Button abort at 12 s left: cooldown 3 clocks after press, no pulse
    step();
    vif.sprinkler_req = 1'b1;
    expect_ev("abort.enter", 3'd1, 30, 1'b0, 1'b0, 0, 1'b1, cyc + 1);
    wait_cyc(2);
    vif.sprinkler_req = 1'b0;
    tick(18);
    do_probe("abort.mid", 3'd1, 12);
    step();
    vif.button = 1'b1;
    expect_ev("abort.btn", 3'd3, 5, 1'b0, 1'b0, 0, 1'b1, cyc + 3);
    wait_cyc(6);
    vif.button = 1'b0;
    expect_ev("abort.gap_end", 3'd0, 0, 1'b0, 1'b1, tick_cnt + 5, 1'b0, 0);
    tick(5);
    wait_cyc(2);

    // Empty tank and button pulse in the same cycle during drip: refill wins
    step();
    vif.water_box = 2'b10;
    vif.drip_req  = 1'b1;
    expect_ev("empty.enter", 3'd2, 20, 1'b0, 1'b0, 0, 1'b1, cyc + 1);
    wait_cyc(2);
    vif.drip_req = 1'b0;
    tick(3);
    do_probe("empty.mid", 3'd2, 17);
    step();
    vif.button = 1'b1;
    p = cyc;
    step();
    step();
    vif.water_box = 2'b00;
    expect_ev("empty.refill", 3'd4, 60, 1'b0, 1'b0, 0, 1'b1, p + 3);
    wait_cyc(4);
    vif.button = 1'b0;
    tick(10);
    do_probe("refill.mid", 3'd4, 50);
    step();
    vif.water_box = 2'b11;
    expect_ev("refill.full", 3'd3, 5, 1'b0, 1'b0, 0, 1'b1, cyc + 1);
    expect_ev("refill.gap_end", 3'd0, 0, 1'b0, 1'b1, tick_cnt + 5, 1'b0, 0);
    tick(5);
    wait_cyc(2);

    // Refill timeout: fault latched, requests ignored, button clears to idle
    step();
    vif.water_box = 2'b00;
    expect_ev("fault.refill", 3'd4, 60, 1'b0, 1'b0, 0, 1'b1, cyc + 1);
    wait_cyc(2);
    tick(59);
    do_probe("fault.last", 3'd4, 1);
    expect_ev("fault.enter", 3'd5, 0, 1'b0, 1'b1, tick_cnt + 1, 1'b0, 0);
    tick(1);
    step();
    vif.water_box     = 2'b11;
    vif.sprinkler_req = 1'b1;
    vif.drip_req      = 1'b1;
    tick(3);
    do_probe("fault.hold", 3'd5, 0);
    step();
    vif.button = 1'b1;
    p = cyc;
    expect_ev("fault.clear", 3'd0, 0, 1'b0, 1'b0, 0, 1'b1, p + 3);
    expect_ev("fault.resume", 3'd1, 30, 1'b0, 1'b0, 0, 1'b1, p + 4);
    wait_cyc(6);
    vif.button        = 1'b0;
    vif.sprinkler_req = 1'b0;
    vif.drip_req      = 1'b0;

    // Asynchronous reset mid-sprinkle closes the valve without a clock edge
    tick(4);
    do_probe("rst.mid", 3'd1, 26);
    @(posedge clk);
    #2;
    expect_ev("rst.idle", 3'd0, 0, 1'b0, 1'b0, 0, 1'b0, 0);
    rst_n = 1'b0;
    #1;
    check("rst.valve_sprinkler", 32'(vif.valve_sprinkler), 0);
    check("rst.state", 32'(vif.state), 0);
    check("rst.seconds_left", 32'(vif.seconds_left), 0);
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(6);

    check("scoreboard.drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/valve_sequencer.md
# valve_sequencer

Sequences the irrigation outputs: turns sensor-derived watering requests and the water-box level into timed, mutually exclusive sprinkler/drip cycles. Also handles cooldown gaps, tank refill and a refill-timeout fault. Sits between the irrigation decision logic and the state/timer display path, and replaces the free-running state machine plus external 30→0 counter with one owner of valve timing. Runs in the clock_50MHz domain and uses the 1 Hz tick as an enable.

## Interface
- SPRINKLER_TIME, 30: sprinkler cycle length in seconds (1..63)
- DRIP_TIME, 20: drip cycle length in seconds (1..63)
- SPECIFIC_TIME, 15: drip length when specific_req is set at cycle start (1..63)
- GAP_TIME, 5: cooldown between cycles in seconds (1..63)
- REFILL_MAX, 60: refill timeout in seconds (1..63)
- clock_50MHz  in  1  system clock, all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- one_hz  in  1  one-cycle tick, synchronous to clock_50MHz
- sprinkler_req  in  1  level request, synchronous
- drip_req  in  1  level request, synchronous
- specific_req  in  1  selects SPECIFIC_TIME for drip, synchronous
- water_box  in  2  level: 00 empty, 01 low, 10 mid, 11 full
- button  in  1  asynchronous push button, active-high
- state  out  3  0 IDLE, 1 SPRINKLE, 2 DRIP, 3 COOLDOWN, 4 REFILL, 5 FAULT
- valve_sprinkler  out  1  sprinkler valve open
- valve_drip  out  1  drip valve open
- pump_fill  out  1  refill pump on
- fault  out  1  refill timeout latched
- seconds_left  out  6  remaining seconds of the current timed state, 0 otherwise
- time_over  out  1  one-cycle pulse when a watering cycle completes normally

## Operation
- All outputs registered. Reset values: state=IDLE, all valves/pump/fault=0, seconds_left=0, time_over=0.
- Valve, pump and fault outputs decode directly from the state register. At most one is 1 at any time.
- button passes through a 2-FF synchronizer and a rising-edge detector to make btn_pulse.
- IDLE transitions, in priority order:
  - water_box==00 → REFILL
  - sprinkler_req && water_box>=10 → SPRINKLE
  - drip_req, or sprinkler_req with water_box==01 → DRIP
  - otherwise stay in IDLE
- Entry loads:
  - SPRINKLE: SPRINKLER_TIME
  - DRIP: SPECIFIC_TIME if specific_req else DRIP_TIME. specific_req is sampled only at entry.
  - COOLDOWN: GAP_TIME
  - REFILL: REFILL_MAX
- Timed states on each one_hz tick:
  - If seconds_left==1: exit and load the next state's value.
  - Otherwise decrement. Duration is exactly N ticks.
- SPRINKLE/DRIP expiry → COOLDOWN with a time_over pulse.
- Aborts from SPRINKLE/DRIP:
  - btn_pulse → COOLDOWN, no pulse
  - water_box==00 → REFILL, no pulse. Empty tank wins over button in the same cycle.
- COOLDOWN expiry → IDLE. COOLDOWN ignores requests and button.
- REFILL:
  - water_box==11 → COOLDOWN (level check wins over a same-cycle timeout).
  - Expiry → FAULT.
- FAULT: all actuators off, fault=1. Leaves only on btn_pulse (→ IDLE) or reset.
- seconds_left is 0 in IDLE and FAULT.

## Timing
- Request-to-valve latency: 1 clock from IDLE (next-state registered).
- Button-to-abort latency: 3 clocks (2 sync + edge register).
- time_over is high for exactly 1 clock, the same cycle state first shows COOLDOWN.
- A one_hz tick coinciding with a state entry is consumed by the transition and does not decrement the new count.
- Asynchronous reset mid-cycle closes all valves immediately. No pulse is emitted on reset release.

## Structure
- Package irrigation_pkg holds:
  - state encoding constants (3-bit)
  - water-level codes (EMPTY/LOW/MID/FULL)
  - the default timing constants
- Sub-module seconds_timer: 6-bit loadable down-counter.
  - Inputs: load, load_value, tick.
  - Outputs: count and an expire flag (tick && count==1).

## Test plan
- sprinkler_req=1, water_box=11, default params → state 1 next clock, valve_sprinkler=1 for exactly 30 ticks. Then time_over pulse, COOLDOWN 5 ticks, IDLE.
- sprinkler_req=1 and drip_req=0 with water_box=01 → DRIP. With specific_req=1 at entry, seconds_left=15. Dropping specific_req mid-cycle changes nothing.
- Button pressed at seconds_left=12 in SPRINKLE → COOLDOWN 3 clocks after the press, time_over never asserted.
- water_box→00 during DRIP, with the button pressed in the same cycle → REFILL, pump_fill=1. water_box=11 after 10 ticks → COOLDOWN.
- REFILL held with water_box=00 for 60 ticks → FAULT, fault=1, all actuators 0, requests ignored. Button → IDLE.
- Assert reset_n=0 mid-SPRINKLE → valve_sprinkler=0 and state=0 without any clock edge.
